uart_rx_8x: RTL and testbench

- 8x-oversampled UART receiver: 8N1 frames on the host-driven serial line (UART_TX pin at top level), 9600 baud from CLK_48M.
- Sits directly downstream of the pin and upstream of the 7-seg display/echo logic in LogiFindFPGATest.
- Delivers each received byte over a valid/ready handshake and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_8x.sv | 158 +++++++++++++++
 tb/tb_uart_rx_8x.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, vote sample indices and baud divider helper.
// Imported by uart_rx_8x and intended for the companion transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam logic [2:0] VOTE_A    = 3'd3;
    localparam logic [2:0] VOTE_B    = 3'd4;
    localparam logic [2:0] VOTE_C    = 3'd5;
    localparam logic [2:0] LAST_SIDX = 3'd7;

    function automatic int unsigned calc_div(
        input int unsigned clk_freq,
        input int unsigned baud,
        input int unsigned os
    );
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-cycle tick every DIV clocks.
// Ports: CLK_48M clock, RST_N sync active-low reset, tick_o oversample tick.
module uart_baud_tick #(
    parameter int unsigned DIV = 625
) (
    input  logic CLK_48M,
    input  logic RST_N,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK_48M) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_8x.sv
// uart_rx_8x: 8x-oversampled 8N1 receiver with 3-sample majority vote.
// Ports: CLK_48M, RST_N, UART_TX line in, RX_DATA/RX_VALID/RX_READY, FRAME_ERR, OVERRUN.
module uart_rx_8x
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 48000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       CLK_48M,
    input  logic       RST_N,
    input  logic       UART_TX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

    logic tick;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .CLK_48M(CLK_48M),
        .RST_N  (RST_N),
        .tick_o (tick)
    );

    logic        sync1_q, sync2_q;
    uart_state_e state_q, state_d;
    logic [2:0]  sidx_q, sidx_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        v3_q, v3_d;
    logic        v4_q, v4_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        rxs;
    logic        vote;
    logic        done;

    assign rxs = sync2_q;
    // Samples 3 and 4 are held; sample 5 is the live line value.
    assign vote = (v3_q & v4_q) | (v3_q & rxs) | (v4_q & rxs);

    always_comb begin
        state_d  = state_q;
        sidx_d   = sidx_q;
        bitcnt_d = bitcnt_q;
        v3_d     = v3_q;
        v4_d     = v4_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        done     = 1'b0;

        if (tick) begin
            sidx_d = sidx_q + 3'd1;
            if (sidx_q == VOTE_A) v3_d = rxs;
            if (sidx_q == VOTE_B) v4_d = rxs;
            unique case (state_q)
                IDLE: begin
                    // Detecting tick counts as sample 0.
                    if (!rxs) begin
                        state_d = START;
                        sidx_d  = 3'd1;
                    end
                end
                START: begin
                    if (sidx_q == VOTE_C && vote) begin
                        state_d = IDLE;
                    end else if (sidx_q == LAST_SIDX) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    if (sidx_q == VOTE_C) shreg_d[bitcnt_q] = vote;
                    if (sidx_q == LAST_SIDX) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    // Decide mid stop bit and return to IDLE early to resync.
                    if (sidx_q == VOTE_C) begin
                        if (vote) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            // A same-cycle handshake frees the holding register.
            if (!valid_q || RX_READY) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && RX_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_48M) begin
        if (!RST_N) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= IDLE;
            sidx_q   <= 3'd0;
            bitcnt_q <= 3'd0;
            v3_q     <= 1'b1;
            v4_q     <= 1'b1;
            shreg_q  <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= UART_TX;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            sidx_q   <= sidx_d;
            bitcnt_q <= bitcnt_d;
            v3_q     <= v3_d;
            v4_q     <= v4_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign RX_DATA   = data_q;
    assign RX_VALID  = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_uart_rx_8x.sv
// tb_uart_rx_8x: scenario tasks driving serial frames into uart_rx_8x.
// A reduced clock rate keeps the divider at 5 clocks per tick.
module tb_uart_rx_8x;

    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OS       = 8;
    localparam int          DIV      = 5;
    localparam int unsigned CLK_FREQ = BAUD * OS * DIV;
    localparam int          BIT      = DIV * OS;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ferr;
    logic       ovr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int   fe_cnt   = 0;
    int   ov_cnt   = 0;
    int   vhigh    = 0;
    int   rise_cyc = 0;
    logic vprev    = 1'b0;

    uart_rx_8x #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .CLK_48M  (clk),
        .RST_N    (rst_n),
        .UART_TX  (tx),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (ready),
        .FRAME_ERR(ferr),
        .OVERRUN  (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side observer: records accepted bytes and pulse counts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && ready) rxq.push_back(rx_data);
            if (rx_valid && !vprev) rise_cyc = cyc;
            if (rx_valid) vhigh++;
            if (ferr) fe_cnt++;
            if (ovr) ov_cnt++;
        end
        vprev = rx_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        rxq.delete();
        expq.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        vhigh  = 0;
    endtask

    task automatic send_bit(input logic b, input int n);
        tx = b;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
        if (stop_low > 0) send_bit(1'b0, stop_low);
        send_bit(1'b1, BIT);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx    = 1'b1;
        ready = 1'b1;
        step(3);
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", rx_valid);
        end
        checks++;
        if (ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", ferr);
        end
        checks++;
        if (ovr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovr got=%b exp=0", ovr);
        end
        rst_n = 1'b1;
        step(2 * BIT);
    endtask

    task automatic test_latency();
        int edge_cyc;
        int lat;
        clear_obs();
        step($urandom_range(1, DIV));
        edge_cyc = cyc;
        send_frame(8'h31, 0);
        step(BIT);
        lat = rise_cyc - edge_cyc;
        checks++;
        if (rxq.size() !== 1 || rxq[0] !== 8'h31) begin
            failures++;
            $display("FAIL lat_data got_n=%0d got=%h exp=31", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        checks++;
        if (lat < 77 * DIV + 3 || lat > 78 * DIV + 2) begin
            failures++;
            $display("FAIL lat_cycles got=%0d exp=%0d..%0d", lat,
                     77 * DIV + 3, 78 * DIV + 2);
        end
        checks++;
        if (vhigh !== 1) begin
            failures++;
            $display("FAIL lat_valid_width got=%0d exp=1", vhigh);
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            failures++;
            $display("FAIL lat_errs got_fe=%0d got_ov=%0d exp=0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        clear_obs();
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            expq.push_back(b);
            step($urandom_range(1, DIV));
            send_frame(b, 0);
            if ($urandom_range(0, 1) == 1) step(BIT * $urandom_range(0, 2));
        end
        step(2 * BIT);
        checks++;
        if (rxq.size() !== expq.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", rxq.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < rxq.size(); k++) begin
            checks++;
            if (rxq[k] !== expq[k]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", k, rxq[k], expq[k]);
            end
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            failures++;
            $display("FAIL b2b_errs got_fe=%0d got_ov=%0d exp=0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        step($urandom_range(1, DIV));
        send_bit(1'b0, 3);
        send_bit(1'b1, 2 * BIT);
        checks++;
        if (rxq.size() !== 0 || fe_cnt !== 0) begin
            failures++;
            $display("FAIL glitch_quiet got_n=%0d got_fe=%0d exp=0", rxq.size(), fe_cnt);
        end
        send_frame(8'h5A, 0);
        step(BIT);
        checks++;
        if (rxq.size() !== 1 || rxq[0] !== 8'h5A) begin
            failures++;
            $display("FAIL glitch_next got_n=%0d got=%h exp=5A", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_frame_err();
        clear_obs();
        step($urandom_range(1, DIV));
        send_frame(8'h55, 2 * BIT);
        step(BIT);
        checks++;
        if (fe_cnt !== 1) begin
            failures++;
            $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt);
        end
        checks++;
        if (rxq.size() !== 0) begin
            failures++;
            $display("FAIL ferr_nodata got_n=%0d exp=0", rxq.size());
        end
        send_frame(8'hA5, 0);
        step(BIT);
        checks++;
        if (rxq.size() !== 1 || rxq[0] !== 8'hA5) begin
            failures++;
            $display("FAIL ferr_next got_n=%0d got=%h exp=A5", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_overrun();
        clear_obs();
        ready = 1'b0;
        step($urandom_range(1, DIV));
        send_frame(8'h12, 0);
        send_frame(8'h34, 0);
        step(BIT);
        checks++;
        if (ov_cnt !== 1) begin
            failures++;
            $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin
            failures++;
            $display("FAIL ovr_hold got_v=%b got=%h exp=1/12", rx_valid, rx_data);
        end
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(1);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_drop_valid got=%b exp=0", rx_valid);
        end
        checks++;
        if (rxq.size() !== 1 || rxq[0] !== 8'h12) begin
            failures++;
            $display("FAIL ovr_consumed got_n=%0d got=%h exp=12", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        ready = 1'b1;
        step(BIT);
    endtask

    task automatic test_vote();
        clear_obs();
        step($urandom_range(1, DIV));
        send_bit(1'b0, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, 4 * DIV - DIV / 2);
        send_bit(1'b1, DIV);
        send_bit(1'b0, BIT - (4 * DIV - DIV / 2) - DIV);
        for (int i = 3; i < 8; i++) send_bit(1'b0, BIT);
        send_bit(1'b1, BIT);
        send_frame(8'hFF, 0);
        step(BIT);
        checks++;
        if (rxq.size() !== 2) begin
            failures++;
            $display("FAIL vote_count got=%0d exp=2", rxq.size());
        end
        checks++;
        if (rxq.size() < 1 || rxq[0] !== 8'h00) begin
            failures++;
            $display("FAIL vote_zero got=%h exp=00", (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        checks++;
        if (rxq.size() < 2 || rxq[1] !== 8'hFF) begin
            failures++;
            $display("FAIL vote_ff got=%h exp=FF", (rxq.size() > 1) ? rxq[1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [7:0] m;
        clear_obs();
        r = 8'($urandom_range(0, 255));
        m = 8'h77;
        ready = 1'b0;
        step($urandom_range(1, DIV));
        send_frame(r, 0);
        step(BIT);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== r) begin
            failures++;
            $display("FAIL rmid_pre got_v=%b got=%h exp=1/%h", rx_valid, rx_data, r);
        end
        send_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) send_bit(m[i], BIT);
        send_bit(m[3], BIT / 2);
        rst_n = 1'b0;
        step(2);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || ferr !== 1'b0 || ovr !== 1'b0) begin
            failures++;
            $display("FAIL rmid_outs got=%b/%h/%b/%b exp=0/00/0/0",
                     rx_valid, rx_data, ferr, ovr);
        end
        rst_n = 1'b1;
        tx    = 1'b1;
        ready = 1'b1;
        step(2 * BIT);
        send_frame(8'hC3, 0);
        step(BIT);
        checks++;
        if (rxq.size() !== 1 || rxq[0] !== 8'hC3) begin
            failures++;
            $display("FAIL rmid_next got_n=%0d got=%h exp=C3", rxq.size(),
                     (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            failures++;
            $display("FAIL rmid_errs got_fe=%0d got_ov=%0d exp=0", fe_cnt, ov_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_vote();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
